// File: rtl/vram_scanout_reader.sv
// VRAM scanout reader: credit-prefetches 64-bit frame-buffer words into a small
// FIFO and streams them out as little-endian 8-bit pixels on a valid/ready port.
module vram_scanout_reader #(
  parameter int ADDR_WIDTH   = 14,
  parameter int FRAME_WORDS  = 12288,
  parameter int READ_LATENCY = 3,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  vram_en,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic [63:0]           vram_dout,
  output logic [7:0]            pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_WIDTH + 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    vram_en_r;
  logic [ADDR_WIDTH-1:0]   vram_addr_r;
  logic [WW-1:0]           issue_cnt_r;
  logic [CW-1:0]           credit_r;
  logic [CW-1:0]           count_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [PW-1:0]           wr_ptr_r;
  logic [2:0]              byte_idx_r;
  logic [WW-1:0]           pop_cnt_r;
  logic [READ_LATENCY-1:0] lat_sr_r;
  logic [63:0]             mem_r [FIFO_DEPTH];
  logic [7:0]              pix_data_r;
  logic                    pix_valid_r;
  logic                    pix_last_r;

  logic                    start_ok_s;
  logic                    abort_s;
  logic                    flush_s;
  logic                    xfer_s;
  logic                    pop_s;
  logic                    wr_s;
  logic                    issue_s;
  logic [CW-1:0]           credit_nxt_s;
  logic [CW-1:0]           count_nxt_s;
  logic [PW-1:0]           rd_ptr_nxt_s;
  logic [PW-1:0]           wr_ptr_nxt_s;
  logic [2:0]              byte_nxt_s;
  logic [WW-1:0]           pop_cnt_nxt_s;
  logic [READ_LATENCY-1:0] lat_sr_nxt_s;
  logic [63:0]             head_s;
  logic [7:0]              pix_data_nxt_s;
  logic                    pix_valid_nxt_s;
  logic                    pix_last_nxt_s;

  // Handshake, issue and flush qualifiers; abort beats start in IDLE.
  always_comb begin
    start_ok_s = (state_r == IDLE) && start && !abort;
    abort_s    = abort && (state_r != IDLE);
    flush_s    = start_ok_s || abort_s;
    xfer_s     = pix_valid_r && pix_ready;
    pop_s      = xfer_s && (byte_idx_r == 3'd7);
    wr_s       = lat_sr_r[READ_LATENCY-1] && !flush_s;
    issue_s    = start_ok_s || ((state_r == FETCH) && !abort_s && (credit_r < DEPTH_C));
  end

  // Next-state of the credit/FIFO/unpack datapath.
  always_comb begin
    credit_nxt_s  = credit_r;
    count_nxt_s   = count_r;
    rd_ptr_nxt_s  = rd_ptr_r;
    wr_ptr_nxt_s  = wr_ptr_r;
    byte_nxt_s    = byte_idx_r;
    pop_cnt_nxt_s = pop_cnt_r;
    lat_sr_nxt_s  = {READ_LATENCY{1'b0}};
    if (flush_s) begin
      credit_nxt_s  = start_ok_s ? CW'(1'b1) : {CW{1'b0}};
      count_nxt_s   = {CW{1'b0}};
      rd_ptr_nxt_s  = {PW{1'b0}};
      wr_ptr_nxt_s  = {PW{1'b0}};
      byte_nxt_s    = 3'd0;
      pop_cnt_nxt_s = {WW{1'b0}};
    end else begin
      if (issue_s && !pop_s) begin
        credit_nxt_s = credit_r + CW'(1'b1);
      end else if (!issue_s && pop_s) begin
        credit_nxt_s = credit_r - CW'(1'b1);
      end else begin
        credit_nxt_s = credit_r;
      end
      if (wr_s && !pop_s) begin
        count_nxt_s = count_r + CW'(1'b1);
      end else if (!wr_s && pop_s) begin
        count_nxt_s = count_r - CW'(1'b1);
      end else begin
        count_nxt_s = count_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s  = rd_ptr_r + PW'(1'b1);
        pop_cnt_nxt_s = pop_cnt_r + WW'(1'b1);
      end else begin
        rd_ptr_nxt_s  = rd_ptr_r;
        pop_cnt_nxt_s = pop_cnt_r;
      end
      if (wr_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PW'(1'b1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (xfer_s) begin
        byte_nxt_s = byte_idx_r + 3'd1;
      end else begin
        byte_nxt_s = byte_idx_r;
      end
      lat_sr_nxt_s[0] = vram_en_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        lat_sr_nxt_s[i] = lat_sr_r[i-1];
      end
    end
    // A word landing into an otherwise-empty FIFO becomes the head directly.
    if (wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_s = vram_dout;
    end else begin
      head_s = mem_r[rd_ptr_nxt_s];
    end
    pix_data_nxt_s  = head_s[{byte_nxt_s, 3'b000} +: 8];
    pix_valid_nxt_s = (count_nxt_s != {CW{1'b0}});
    pix_last_nxt_s  = pix_valid_nxt_s && (byte_nxt_s == 3'd7) && (pop_cnt_nxt_s == LAST_WORD);
  end

  // Frame sequencer: issue addresses, busy/done and the read-enable port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      vram_en_r   <= 1'b0;
      vram_addr_r <= {ADDR_WIDTH{1'b0}};
      issue_cnt_r <= {WW{1'b0}};
    end else begin
      done_r    <= 1'b0;
      vram_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            busy_r      <= 1'b1;
            vram_en_r   <= 1'b1;
            vram_addr_r <= {ADDR_WIDTH{1'b0}};
            issue_cnt_r <= WW'(1'b1);
            state_r     <= (LAST_WORD == {WW{1'b0}}) ? DRAIN : FETCH;
          end
        end
        FETCH: begin
          if (abort_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (issue_s) begin
            vram_en_r   <= 1'b1;
            vram_addr_r <= issue_cnt_r[ADDR_WIDTH-1:0];
            issue_cnt_r <= issue_cnt_r + WW'(1'b1);
            if (issue_cnt_r == LAST_WORD) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (xfer_s && pix_last_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Credit, FIFO pointers, latency pipe and registered pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r    <= {CW{1'b0}};
      count_r     <= {CW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      byte_idx_r  <= 3'd0;
      pop_cnt_r   <= {WW{1'b0}};
      lat_sr_r    <= {READ_LATENCY{1'b0}};
      pix_data_r  <= 8'd0;
      pix_valid_r <= 1'b0;
      pix_last_r  <= 1'b0;
    end else begin
      credit_r    <= credit_nxt_s;
      count_r     <= count_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      byte_idx_r  <= byte_nxt_s;
      pop_cnt_r   <= pop_cnt_nxt_s;
      lat_sr_r    <= lat_sr_nxt_s;
      pix_data_r  <= pix_data_nxt_s;
      pix_valid_r <= pix_valid_nxt_s;
      pix_last_r  <= pix_last_nxt_s;
    end
  end

  // Word storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= vram_dout;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign vram_en   = vram_en_r;
  assign vram_addr = vram_addr_r;
  assign pix_data  = pix_data_r;
  assign pix_valid = pix_valid_r;
  assign pix_last  = pix_last_r;

endmodule
